pipelined_adder: RTL and testbench

Parametrised successor to the team's 4-bit ripple-carry adder. Adds or subtracts WIDTH-bit operands through a STAGES-deep carry-pipelined datapath, one operation per clock at full throughput. Uses valid/ready handshakes on both sides so it can sit between streaming producers and consumers in the lab datapath. Reports carry-out, signed overflow and zero flags alongside the sum.

---
 rtl/pipelined_adder_pkg.sv | 5 +
 rtl/adder_slice.sv | 16 +
 rtl/pipelined_adder.sv | 106 ++++++++++
 tb/tb_pipelined_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: operation mode encodings shared by the adder and the ALU work that follows
package pipelined_adder_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: SLICE-bit combinational add
// Ports: i_a, i_b operand slices; i_c carry in; o_s sum slice; o_c carry out of MSB; o_cm carry into MSB
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_c,
  output logic [SLICE-1:0] o_s,
  output logic             o_c,
  output logic             o_cm
);
  assign {o_c, o_s} = (SLICE+1)'(i_a) + (SLICE+1)'(i_b) + (SLICE+1)'(i_c);
  // The MSB sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out of it directly.
  assign o_cm = o_s[SLICE-1] ^ i_a[SLICE-1] ^ i_b[SLICE-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub, carry pipelined over STAGES slices, valid/ready on both sides
// Ports: clk, rst_n (async, active low); in_valid/in_ready/A/B/Cin/mode carry one operand beat;
//        out_valid/out_ready/Sum/Couts/Ovf/Zero carry one registered result beat.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Couts,
  output logic             Ovf,
  output logic             Zero
);
  localparam int SLICE = WIDTH / STAGES;
  logic [STAGES-1:0] w_v, w_load;
  if (WIDTH % STAGES != 0) begin : g_chk
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end
  // A stage loads when empty or when its successor loads, so bubbles collapse behind a stalled output.
  always_comb begin
    w_load = '0;
    w_load[STAGES-1] = !w_v[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) w_load[i] = !w_v[i] || w_load[i+1];
  end
  assign in_ready = w_load[0];
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits still to be added (skew) shrink by one slice per stage; the finished sum (deskew) grows.
    localparam int AW = WIDTH - k * SLICE;
    logic [AW-1:0] w_a, w_b;
    logic [(k+1)*SLICE-1:0] w_full, r_s;
    logic [SLICE-1:0] w_slice;
    logic w_ci, w_vin, w_co, w_cm, r_v, r_c;
    if (k == 0) begin : g_head
      // SUB is A + ~B + 1: invert B and force the carry-in.
      assign w_a = A;
      assign w_b = mode == MODE_SUB ? ~B : B;
      assign w_ci = mode == MODE_SUB ? 1'b1 : Cin;
      assign w_vin = in_valid;
      assign w_full = w_slice;
    end else begin : g_tail
      assign w_a = g_st[k-1].g_fwd.r_a;
      assign w_b = g_st[k-1].g_fwd.r_b;
      assign w_ci = g_st[k-1].r_c;
      assign w_vin = g_st[k-1].r_v;
      assign w_full = {w_slice, g_st[k-1].r_s};
    end
    adder_slice #(.SLICE(SLICE)) u_slice (
      .i_a (w_a[SLICE-1:0]),
      .i_b (w_b[SLICE-1:0]),
      .i_c (w_ci),
      .o_s (w_slice),
      .o_c (w_co),
      .o_cm(w_cm)
    );
    assign w_v[k] = r_v;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_load[k]) begin
        r_v <= w_vin;
        r_c <= w_co;
        r_s <= w_full;
      end
    if (k < STAGES - 1) begin : g_fwd
      logic [AW-SLICE-1:0] r_a, r_b;
      logic w_unused_cm;
      assign w_unused_cm = w_cm;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_load[k]) begin
          r_a <= w_a[AW-1:SLICE];
          r_b <= w_b[AW-1:SLICE];
        end
    end else begin : g_last
      logic r_ovf, r_zero;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          r_ovf <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_load[k]) begin
          r_ovf <= w_cm ^ w_co;
          r_zero <= ~|w_full;
        end
      assign out_valid = r_v;
      assign Sum = r_s;
      assign Couts = r_c;
      assign Ovf = r_ovf;
      assign Zero = r_zero;
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: table, directed and random checks of pipelined_adder against an arithmetic model
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;
  localparam int W = 16;
  logic clk = 0, rst_n = 1;
  logic in_valid = 0, in_ready, Cin = 0, mode = 0, out_valid, out_ready = 1, Couts, Ovf, Zero;
  logic [W-1:0] A = '0, B = '0, Sum;
  logic d_in_valid = 0, d_in_ready, d_cin = 0, d_mode = 0, d_out_valid, d_out_ready = 1;
  logic d_couts, d_ovf, d_zero;
  logic [7:0] d_a = '0, d_b = '0, d_sum;
  int checks = 0, errors = 0;
  logic acc_last = 0;
  typedef struct { logic [W-1:0] sum; logic c, v, z; } res_t;
  typedef struct { logic [W-1:0] a, b; logic cin, m; logic [W-1:0] sum; logic c, v, z; } vec_t;
  res_t q[$];
  always #5 clk = ~clk;
  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .Cin(Cin),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Couts(Couts), .Ovf(Ovf),
    .Zero(Zero)
  );
  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .A(d_a), .B(d_b),
    .Cin(d_cin), .mode(d_mode), .out_valid(d_out_valid), .out_ready(d_out_ready), .Sum(d_sum),
    .Couts(d_couts), .Ovf(d_ovf), .Zero(d_zero)
  );
  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction
  // Reference: plain integer arithmetic; carry = unsigned overflow (ADD) or no-borrow (SUB).
  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic m);
    res_t r;
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int u = int'(a) + int'(b) + int'(cin);
    int s;
    if (m == MODE_SUB) begin
      r.sum = a - b;
      r.c = a >= b;
      s = sa - sb;
    end else begin
      r.sum = u[W-1:0];
      r.c = u > 65535;
      s = sa + sb + int'(cin);
    end
    r.v = s > 32767 || s < -32768;
    r.z = r.sum == 0;
    return r;
  endfunction
  function automatic void check_res(string name, res_t e);
    check({name, "_sum"}, Sum, e.sum);
    check({name, "_couts"}, Couts, e.c);
    check({name, "_ovf"}, Ovf, e.v);
    check({name, "_zero"}, Zero, e.z);
  endfunction
  // Scoreboard: every cycle with out_valid the outputs must equal the oldest outstanding beat.
  initial forever begin
    @(negedge clk);
    if (!rst_n) q.delete();
    else begin
      if (out_valid) begin
        if (q.size() == 0) check("spurious_out_valid", out_valid, 0);
        else begin
          check_res("sb", q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(A, B, Cin, mode));
      acc_last = in_valid && in_ready;
    end
  end
  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic m);
    logic ok = 0;
    A = a; B = b; Cin = c; mode = m; in_valid = 1;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("drive_timeout", ok, 1);
    in_valid = 0;
  endtask
  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic m,
                            output int lat);
    @(posedge clk);
    #1;
    A = a; B = b; Cin = c; mode = m; in_valid = 1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 0;
      lat++;
    end while (!out_valid && lat < 20);
  endtask
  initial begin
    vec_t tbl[11];
    int lat, seen;
    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{16'h8000, 16'h0001, 1'b0, MODE_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{16'h0003, 16'h0005, 1'b0, MODE_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{16'h7FFF, 16'h0001, 1'b0, MODE_ADD, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{16'h1234, 16'h4321, 1'b1, MODE_ADD, 16'h5556, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'h1234, 16'h1234, 1'b1, MODE_SUB, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, MODE_ADD, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{16'h0FFF, 16'h0000, 1'b1, MODE_ADD, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{16'h00FF, 16'h0001, 1'b0, MODE_ADD, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{16'h0000, 16'h0001, 1'b0, MODE_SUB, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{16'h7FFF, 16'hFFFF, 1'b0, MODE_SUB, 16'h8000, 1'b0, 1'b1, 1'b0};
    #1 rst_n = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_couts", Couts, 0);
    check("rst_ovf", Ovf, 0);
    check("rst_zero", Zero, 0);
    check("rst_d1_out_valid", d_out_valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    foreach (tbl[i]) begin
      run_single(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].m, lat);
      check($sformatf("tbl%0d_latency", i), lat, 4);
      check($sformatf("tbl%0d_sum", i), Sum, tbl[i].sum);
      check($sformatf("tbl%0d_couts", i), Couts, tbl[i].c);
      check($sformatf("tbl%0d_ovf", i), Ovf, tbl[i].v);
      check($sformatf("tbl%0d_zero", i), Zero, tbl[i].z);
    end
    @(posedge clk);
    #1;
    A = 0; B = 0; Cin = 0; mode = MODE_ADD; in_valid = 1;
    for (int t = 1; t <= 14; t++) begin
      @(posedge clk);
      #1;
      check("b2b_in_ready", in_ready, 1);
      check($sformatf("b2b_valid_c%0d", t), out_valid, t >= 4 && t <= 11);
      if (t >= 4 && t <= 11) check($sformatf("b2b_sum_c%0d", t), Sum, 16'(16'h1112 * (t - 4)));
      if (t < 8) begin
        A = 16'(t);
        B = 16'(16'h1111 * t);
      end else in_valid = 0;
    end
    @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 8; i++) drive_beat(16'(i), 16'(16'h1111 * i), 1'b0, MODE_ADD);
      for (int t = 1; t <= 13; t++) begin
        @(posedge clk);
        #1;
        if (t == 3) out_ready = 0;
        if (t == 13) out_ready = 1;
        if (t >= 4 && t <= 12) begin
          check($sformatf("bp_in_ready_c%0d", t), in_ready, 0);
          check($sformatf("bp_out_valid_c%0d", t), out_valid, 1);
        end
      end
    join
    for (int w = 0; w < 50 && q.size() != 0; w++) @(posedge clk);
    check("bp_drained", q.size(), 0);
    @(posedge clk);
    #1;
    out_ready = 0;
    for (int i = 0; i < 3; i++) drive_beat(16'(i + 1), 16'h0100, 1'b0, MODE_ADD);
    @(posedge clk);
    #1;
    check("rs_pre_out_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("rs_out_valid", out_valid, 0);
    check("rs_sum", Sum, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen += int'(out_valid);
    end
    check("rs_no_ghost", seen, 0);
    run_single(16'hABCD, 16'h1111, 1'b0, MODE_ADD, lat);
    check("rs_new_latency", lat, 4);
    check("rs_new_sum", Sum, 16'hBCDE);
    @(posedge clk);
    #1;
    d_a = 8'h7F; d_b = 8'h01; d_cin = 0; d_mode = MODE_ADD; d_in_valid = 1;
    check("s1_pre_valid", d_out_valid, 0);
    @(posedge clk);
    #1;
    d_in_valid = 0;
    check("s1_valid", d_out_valid, 1);
    check("s1_sum", d_sum, 8'h80);
    check("s1_ovf", d_ovf, 1);
    check("s1_couts", d_couts, 0);
    check("s1_zero", d_zero, 0);
    d_a = 8'h00; d_b = 8'h01; d_mode = MODE_SUB; d_in_valid = 1;
    @(posedge clk);
    #1;
    d_in_valid = 0;
    check("s1_sub_sum", d_sum, 8'hFF);
    check("s1_sub_couts", d_couts, 0);
    check("s1_sub_ovf", d_ovf, 0);
    @(posedge clk);
    #1;
    check("s1_idle_valid", d_out_valid, 0);
    begin
      int sent = 0;
      for (int cyc = 0; cyc < 3000 && sent < 400; cyc++) begin
        @(posedge clk);
        #1;
        if (acc_last) sent++;
        if (!in_valid || acc_last) begin
          in_valid = $urandom_range(0, 9) < 7;
          A = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom);
          B = $urandom_range(0, 7) == 0 ? 16'h8000 : 16'($urandom);
          Cin = 1'($urandom);
          mode = 1'($urandom);
        end
        out_ready = $urandom_range(0, 9) < 7;
      end
      check("rand_sent_enough", sent >= 400, 1);
    end
    in_valid = 0;
    out_ready = 1;
    for (int w = 0; w < 50 && q.size() != 0; w++) @(posedge clk);
    check("rand_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
